sbi_master: RTL

- Burst master that drives the simple burst interface (SBI) bus from a command/data stream front end.
- Accepts a burst command (address, length, direction).
- Issues bSTART, then paced bACCESS beats, feeding write data from a valid/ready stream.
- Collects bVALID/bQ read returns into a small credit-protected FIFO exposed as a valid/ready stream.
- Sits directly upstream of the SBI memory-side interface block.

---
 rtl/sbi_pkg.sv | 29 ++
 rtl/sbi_rd_fifo.sv | 56 +++++
 rtl/sbi_master.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/sbi_pkg.sv
// Shared types for the simple burst interface (SBI): master FSM states,
// the burst-command struct and width helpers.
package sbi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      BURST = 2'd2
   } sbi_mst_state_e;

   // Default bus geometry: 256 words, 16-beat bursts.
   localparam int unsigned SBI_AW = 8;
   localparam int unsigned SBI_LW = 4;

   typedef struct packed {
      logic [SBI_AW-1:0] addr;
      logic              write;
      logic [SBI_LW-1:0] len;
   } sbi_cmd_t;

   function automatic int unsigned sbi_ptr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int unsigned sbi_cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/sbi_rd_fifo.sv
// Synchronous FIFO for SBI read returns; Depth must be a power of two so the
// pointers wrap naturally. Simultaneous push and pop is legal at any occupancy.
module sbi_rd_fifo
   import sbi_pkg::*;
#(
   parameter int unsigned Width = 32,
   parameter int unsigned Depth = 4,
   localparam int unsigned Pw   = sbi_ptr_w(Depth),
   localparam int unsigned Cw   = sbi_cnt_w(Depth)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   output logic [Width-1:0] data_o,
   output logic [Cw-1:0]    count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [Width-1:0] mem_q [Depth];
   logic [Pw-1:0]    wptr_q, rptr_q;
   logic [Cw-1:0]    count_q;
   logic             wr_en, rd_en;

   assign full_o  = (count_q == Cw'(Depth));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rptr_q];

   // A full FIFO may still accept a push when the head is leaving this cycle.
   assign wr_en = push_i & (~full_o | pop_i);
   assign rd_en = pop_i & ~empty_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (wr_en) wptr_q <= wptr_q + 1'b1;
         if (rd_en) rptr_q <= rptr_q + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wptr_q] <= data_i;
   end

endmodule

// File: rtl/sbi_master.sv
// SBI burst master: command in, bSTART + paced bACCESS beats out, read returns
// into a credit-protected FIFO. Define SBI_MASTER_ERR_EN to build the err_o checks.
module sbi_master
   import sbi_pkg::*;
#(
   parameter int unsigned Width       = 32,
   parameter int unsigned Depth       = 256,
   parameter int unsigned MaxLen      = 16,
   parameter int unsigned RdFifoDepth = 4,
   localparam int unsigned Aw         = $clog2(Depth),
   localparam int unsigned Lw         = $clog2(MaxLen),
   localparam int unsigned Cw         = sbi_cnt_w(RdFifoDepth)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic [Aw-1:0]    cmd_addr_i,
   input  logic             cmd_write_i,
   input  logic [Lw-1:0]    cmd_len_i,
   input  logic             wdata_valid_i,
   output logic             wdata_ready_o,
   input  logic [Width-1:0] wdata_i,
   output logic             rdata_valid_o,
   input  logic             rdata_ready_i,
   output logic [Width-1:0] rdata_o,
   output logic             busy_o,
   output logic             err_o,
   output logic [Aw-1:0]    bADDR,
   output logic             bSTART,
   output logic             bACCESS,
   output logic             bWRITE,
   output logic [Width-1:0] bD,
   input  logic [Width-1:0] bQ,
   input  logic             bVALID
);

   sbi_mst_state_e  state_q, state_d;
   logic [Aw-1:0]   addr_q, addr_d;
   logic            wr_q, wr_d;
   logic [Lw-1:0]   cnt_q, cnt_d;
   logic            inflight_q, inflight_d;
   logic            access;
   logic            credit_ok;
   logic [Cw-1:0]   fifo_count;
   logic [Cw:0]     occupancy;
   logic            fifo_full, fifo_empty;

   // A read beat needs a free FIFO slot counting the return still on the bus.
   assign occupancy = {1'b0, fifo_count} + {{Cw{1'b0}}, inflight_q};
   assign credit_ok = occupancy < (Cw + 1)'(RdFifoDepth);

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      wr_d          = wr_q;
      cnt_d         = cnt_q;
      bSTART        = 1'b0;
      access        = 1'b0;
      wdata_ready_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_valid_i) begin
               addr_d  = cmd_addr_i;
               wr_d    = cmd_write_i;
               cnt_d   = cmd_len_i;
               state_d = START;
            end
         end
         START: begin
            bSTART  = 1'b1;
            state_d = BURST;
         end
         BURST: begin
            wdata_ready_o = wr_q;
            access        = wr_q ? wdata_valid_i : credit_ok;
            if (access) begin
               if (cnt_q == '0) state_d = IDLE;
               else             cnt_d   = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign inflight_d  = access & ~wr_q;
   assign cmd_ready_o = (state_q == IDLE);
   assign bACCESS     = access;
   assign bADDR       = addr_q;
   assign bWRITE      = wr_q;
   assign bD          = wdata_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         wr_q       <= 1'b0;
         cnt_q      <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wr_q       <= wr_d;
         cnt_q      <= cnt_d;
         inflight_q <= inflight_d;
      end
   end

   sbi_rd_fifo #(
      .Width (Width),
      .Depth (RdFifoDepth)
   ) u_rd_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (bVALID),
      .data_i  (bQ),
      .pop_i   (rdata_ready_i & ~fifo_empty),
      .data_o  (rdata_o),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign rdata_valid_o = ~fifo_empty;
   assign busy_o        = (state_q != IDLE) | inflight_q | ~fifo_empty;

`ifdef SBI_MASTER_ERR_EN
   logic          err_q, err_d;
   logic [Aw:0]   end_addr;
   logic          wrap_err, ret_err;

   assign end_addr = {1'b0, cmd_addr_i} + (Aw + 1)'(cmd_len_i);
   assign wrap_err = cmd_valid_i & cmd_ready_o & (end_addr >= (Aw + 1)'(Depth));
   // A return with no read outstanding or no room means the bus misbehaved.
   assign ret_err  = bVALID & (fifo_full | ~inflight_q);
   assign err_d    = err_q | wrap_err | ret_err;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) err_q <= 1'b0;
      else         err_q <= err_d;
   end

   assign err_o = err_q;
`else
   logic unused_fifo_full;
   assign unused_fifo_full = fifo_full;
   assign err_o            = 1'b0;
`endif

endmodule
